// File: rtl/count_hex_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : count_hex_display
// Brief   : Two-digit hex display of an 8-bit counter with freeze/hold,
//           leading-zero blanking and a sticky wrap flag. Defining the macro
//           HEX_BLINK_EN makes the held digits blink while frozen.
// Revision: 1.0
// ----------------------------------------------------------------------------
module count_hex_display #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       freeze_btn,
  input  logic       lz_en,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       wrap,
  output logic       frozen
);

  localparam logic [6:0] c_BLANK = 7'h7F;

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_prev_btn;
  logic       w_edge;
  logic       w_update;
  logic       r_wrap;
  logic [7:0] r_last_val;
  logic [6:0] r_held0;
  logic [6:0] r_held1;
  logic [6:0] w_held0_next;
  logic [6:0] w_held1_next;
  logic [6:0] w_enc0;
  logic [6:0] w_enc1;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  generate
    if (BLINK_DIV < 1) begin : g_bad_div
      $error("count_hex_display: BLINK_DIV must be at least 1");
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= SHOW;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_edge       = freeze_btn & ~r_prev_btn;
    w_state_next = r_state;
    if (w_edge) begin
      w_state_next = (r_state == SHOW) ? HOLD : SHOW;
    end
  end

  // A load reaches the display in SHOW, or in HOLD when it coincides with the release edge.
  always_comb begin
    w_update     = load & ((r_state == SHOW) | w_edge);
    w_enc0       = f_seg(value[3:0]);
    w_enc1       = (lz_en && (value[7:4] == 4'h0)) ? c_BLANK : f_seg(value[7:4]);
    w_held0_next = w_update ? w_enc0 : r_held0;
    w_held1_next = w_update ? w_enc1 : r_held1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_prev_btn <= 1'b0;
      r_last_val <= 8'h00;
      r_wrap     <= 1'b0;
      r_held0    <= c_BLANK;
      r_held1    <= c_BLANK;
    end else begin
      r_prev_btn <= freeze_btn;
      r_held0    <= w_held0_next;
      r_held1    <= w_held1_next;
      if (load) begin
        if (value < r_last_val) begin
          r_wrap <= 1'b1;
        end
        r_last_val <= value;
      end
    end
  end

  assign frozen = (r_state == HOLD);
  assign wrap   = r_wrap;

`ifdef HEX_BLINK_EN
  localparam int                 c_CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_DIV - 1);

  logic [c_CNT_W-1:0] r_blink_cnt;
  logic [c_CNT_W-1:0] w_blink_cnt_next;
  logic               r_blink_phase;
  logic               w_blink_phase_next;
  logic [6:0]         r_hex0;
  logic [6:0]         r_hex1;

  // Counter and phase restart on every HOLD entry so the first phase shows digits.
  always_comb begin
    w_blink_cnt_next   = '0;
    w_blink_phase_next = 1'b0;
    if ((r_state == HOLD) && (w_state_next == HOLD)) begin
      if (r_blink_cnt == c_CNT_MAX) begin
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_blink_cnt_next   = r_blink_cnt + c_CNT_W'(1);
        w_blink_phase_next = r_blink_phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_hex0        <= c_BLANK;
      r_hex1        <= c_BLANK;
    end else begin
      r_blink_cnt   <= w_blink_cnt_next;
      r_blink_phase <= w_blink_phase_next;
      r_hex0        <= w_blink_phase_next ? c_BLANK : w_held0_next;
      r_hex1        <= w_blink_phase_next ? c_BLANK : w_held1_next;
    end
  end

  assign HEX0 = r_hex0;
  assign HEX1 = r_hex1;
`else
  assign HEX0 = r_held0;
  assign HEX1 = r_held1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_hex_display.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_count_hex_display
// Brief   : Self-checking bench for count_hex_display (directed + random).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_count_hex_display;

  localparam int TB_DIV = 4;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] value = 8'h00;
  logic       load = 1'b0;
  logic       freeze_btn = 1'b0;
  logic       lz_en = 1'b0;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic       wrap;
  logic       frozen;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16];

  // Reference model state
  logic       m_frozen;
  logic       m_wrap;
  logic       m_prev;
  logic [7:0] m_last;
  logic [6:0] m_d0;
  logic [6:0] m_d1;
  int         m_hc;

  count_hex_display #(.BLINK_DIV(TB_DIV)) dut (
    .clk        (clk),
    .clear      (clear),
    .value      (value),
    .load       (load),
    .freeze_btn (freeze_btn),
    .lz_en      (lz_en),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .wrap       (wrap),
    .frozen     (frozen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs.
  task automatic step(input string tag, input logic c, input logic ld, input logic [7:0] v,
                      input logic b, input logic lz);
    logic       e;
    logic       upd;
    logic       blank;
    @(negedge clk);
    clear = c; load = ld; value = v; freeze_btn = b; lz_en = lz;
    @(posedge clk);
    if (c) begin
      m_frozen = 1'b0; m_wrap = 1'b0; m_prev = 1'b0; m_last = 8'h00;
      m_d0 = 7'h7F; m_d1 = 7'h7F; m_hc = 0;
    end else begin
      e      = b && !m_prev;
      m_prev = b;
      upd    = ld && (!m_frozen || e);
      if (ld) begin
        if (v < m_last) m_wrap = 1'b1;
        m_last = v;
      end
      if (upd) begin
        m_d0 = seg_tab[v[3:0]];
        m_d1 = (lz && v[7:4] == 4'h0) ? 7'h7F : seg_tab[v[7:4]];
      end
      if (e) begin
        m_frozen = !m_frozen;
        m_hc     = 0;
      end else if (m_frozen) begin
        m_hc++;
      end
    end
`ifdef HEX_BLINK_EN
    blank = m_frozen && (((m_hc / TB_DIV) % 2) == 1);
`else
    blank = 1'b0;
`endif
    #1;
    chk({tag, ".frozen"}, {7'b0, frozen}, {7'b0, m_frozen});
    chk({tag, ".wrap"},   {7'b0, wrap},   {7'b0, m_wrap});
    chk({tag, ".HEX0"},   {1'b0, HEX0},   {1'b0, blank ? 7'h7F : m_d0});
    chk({tag, ".HEX1"},   {1'b0, HEX1},   {1'b0, blank ? 7'h7F : m_d1});
  endtask

  initial begin
    logic       rb;
    logic       rc;
    logic       rl;
    logic       rz;
    logic [7:0] rv;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset state
    step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset.hex", {1'b0, HEX1}, 8'h7F);

    // Basic load, latency 1
    step("load3A", 1'b0, 1'b1, 8'h3A, 1'b0, 1'b0);
    chk("r31.hex1", {1'b0, HEX1}, 8'h30);
    chk("r31.hex0", {1'b0, HEX0}, 8'h08);

    // Leading-zero blanking
    step("reset2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("lz07", 1'b0, 1'b1, 8'h07, 1'b0, 1'b1);
    chk("r32.hex1a", {1'b0, HEX1}, 8'h7F);
    chk("r32.hex0a", {1'b0, HEX0}, 8'h78);
    step("lzchg", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("lz10", 1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
    chk("r32.hex1b", {1'b0, HEX1}, 8'h79);
    chk("r32.hex0b", {1'b0, HEX0}, 8'h40);

    // Sticky wrap
    step("wrapFF", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    step("wrap00", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("r33.wrap_set", {7'b0, wrap}, 8'h01);
    step("wrap01", 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    step("wrap02", 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    chk("r33.wrap_stay", {7'b0, wrap}, 8'h01);
    step("wrapclr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("r33.wrap_clr", {7'b0, wrap}, 8'h00);

    // Freeze / hold / release with simultaneous load
    step("show12", 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    step("frz1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("r34.frozen", {7'b0, frozen}, 8'h01);
    step("frz1lo", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("hold99", 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("r34.hold_hex0", {1'b0, HEX0}, 8'h24);
    step("rel55", 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("r34.released", {7'b0, frozen}, 8'h00);
    chk("r34.hex1_55", {1'b0, HEX1}, 8'h12);
    step("rel55lo", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Load and freeze edge together in SHOW: new value held
    step("ldfrz", 1'b0, 1'b1, 8'hC4, 1'b1, 1'b0);
    step("ldfrzlo", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("ldfrzlo2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Clear overrides load and freeze edge mid-HOLD
    step("clrhold", 1'b1, 1'b1, 8'hAB, 1'b1, 1'b0);
    chk("r27.frozen", {7'b0, frozen}, 8'h00);
    chk("r27.hex0", {1'b0, HEX0}, 8'h7F);

    // Long press: exactly one toggle
    for (int i = 0; i < 10; i++) step("longpress", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("r36.one_toggle", {7'b0, frozen}, 8'h01);
    step("longrel", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("unfrz", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("unfrzlo", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Hold display over two full blink periods
    step("clrb", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("b12", 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    step("bentry", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("r35.entry_hex0", {1'b0, HEX0}, 8'h24);
    for (int i = 1; i < 2 * TB_DIV + 1; i++) begin
      step("bhold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef HEX_BLINK_EN
      chk("r35.blink_hex1", {1'b0, HEX1}, (i >= TB_DIV && i < 2 * TB_DIV) ? 8'h7F : 8'h79);
`else
      chk("r30.steady_hex1", {1'b0, HEX1}, 8'h79);
`endif
    end
    for (int i = 0; i < TB_DIV - 1; i++) step("bhold2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("bclr", 1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
    chk("r35.clr_frozen", {7'b0, frozen}, 8'h00);
    chk("r35.clr_hex1", {1'b0, HEX1}, 8'h7F);

    // Random traffic against the model
    rb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 63) == 0);
      rl = ($urandom_range(0, 1) == 1);
      rz = ($urandom_range(0, 3) == 0);
      rv = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) rb = ~rb;
      step("rand", rc, rl, rv, rb, rz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
